uart_rx: RTL and testbench

- Serial receiver half of the team's 8N1 UART; the counterpart of the existing transmitter.
- Samples the asynchronous `i_rx` line, recovers 8-bit frames (1 start bit, 8 data bits LSB-first, 1 stop bit) and delivers each byte as a single-cycle valid pulse.
- Rejects start-bit glitches and flags framing errors.
- Sits between the board RX pin and the application/loopback logic; shares clock, reset and baud configuration with the transmitter.

---
 rtl/uart_rx_pkg.sv | 9 +
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_sync_2ff.sv | 15 +
 rtl/uart_rx.sv | 82 ++++++++
 tb/tb_uart_rx.sv | 123 ++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: frame constants, receiver states and baud timing shared with the transmitter
package uart_rx_pkg;
  localparam int data_bits = 8;
  localparam int stop_bits = 1;
  typedef enum logic [2:0] {s_idle, s_start, s_data, s_stop, s_wait_high} state_t;
  function automatic int calc_clk_cycle(input int freq_mhz, input int baud);
    return (freq_mhz * 1000000) / baud;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and status pulses out
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  modport master (input rx, output data, valid, frame_err, busy);
  modport slave (output rx, input data, valid, frame_err, busy);
endinterface

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff: two-flop synchronizer for an asynchronous input with a configurable reset level
module uart_sync_2ff #(
  parameter logic rst_val = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the asynchronous input through two flops to settle metastability
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) {q, meta} <= {rst_val, rst_val};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with start-glitch rejection and framing-error detection
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int clk_frequency = 27,
  parameter int baud_rate = 115200
) (
  input logic       i_clk,
  input logic       i_rst_n,
  uart_rx_if.master bus
);
  localparam int clk_cycle = calc_clk_cycle(clk_frequency, baud_rate);
  localparam int half_cycle = clk_cycle / 2;
  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  sh, sh_nxt, data_nxt;
  logic        valid_nxt, err_nxt, rx_s;
  uart_sync_2ff #(.rst_val(1'b1)) sync (.i_clk(i_clk), .i_rst_n(i_rst_n), .d(bus.rx), .q(rx_s));
  assign bus.busy = (state != s_idle);
  // register state, counters, shift register and the one-cycle output pulses
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state         <= s_idle;
      cnt           <= '0;
      idx           <= '0;
      sh            <= '0;
      bus.data      <= '0;
      bus.valid     <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      idx           <= idx_nxt;
      sh            <= sh_nxt;
      bus.data      <= data_nxt;
      bus.valid     <= valid_nxt;
      bus.frame_err <= err_nxt;
    end
  // sample each bit at its centre; leave at mid-stop so a back-to-back start edge is caught
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 16'd1;
    idx_nxt   = idx;
    sh_nxt    = sh;
    data_nxt  = bus.data;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      s_idle: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        state_nxt = rx_s ? s_idle : s_start;
      end
      s_start:
        if (cnt == 16'(half_cycle - 1)) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? s_idle : s_data;
        end
      s_data:
        if (cnt == 16'(clk_cycle - 1)) begin
          cnt_nxt     = '0;
          sh_nxt[idx] = rx_s;
          idx_nxt     = idx + 3'd1;
          state_nxt   = (idx == 3'(data_bits - 1)) ? s_stop : s_data;
        end
      s_stop:
        if (cnt == 16'(clk_cycle - 1)) begin
          cnt_nxt   = '0;
          data_nxt  = rx_s ? sh : bus.data;
          valid_nxt = rx_s;
          err_nxt   = !rx_s;
          state_nxt = rx_s ? s_idle : s_wait_high;
        end
      s_wait_high: begin
        cnt_nxt = '0;
        state_nxt = rx_s ? s_idle : s_wait_high;
      end
      default: state_nxt = s_idle;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked against an event-queue model of the receiver
module tb_uart_rx;
  localparam int cc = (27 * 1000000) / 115200;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int last_valid_cyc = 0;
  logic prev_pulse = 1'b0;
  logic [7:0] last_good = 8'h00;
  logic [8:0] q[$];
  logic [8:0] e;
  uart_rx_if bus();
  uart_rx #(.clk_frequency(27), .baud_rate(115200)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic hold(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    hold(1'b0, cc);
    for (int i = 0; i < 8; i++) hold(b[i], cc);
    hold(stop_ok, cc);
  endtask
  task automatic send_good(input logic [7:0] b);
    q.push_back({1'b0, b});
    last_good = b;
    fall_cyc = cyc;
    send_frame(b, 1'b1);
  endtask
  task automatic send_bad(input logic [7:0] b);
    q.push_back({1'b1, last_good});
    send_frame(b, 1'b0);
    hold(1'b1, cc);
  endtask
  // every output pulse must match the oldest outstanding expected event
  always @(negedge clk) begin
    if (rst_n && (bus.valid || bus.frame_err)) begin
      check("exclusive", {31'd0, bus.valid & bus.frame_err}, 0);
      check("single_cycle", {31'd0, prev_pulse}, 0);
      if (q.size() == 0) check("spurious", {30'd0, bus.frame_err, bus.valid}, 0);
      else begin
        e = q.pop_front();
        check("kind", {31'd0, bus.frame_err}, {31'd0, e[8]});
        check("data", {24'd0, bus.data}, {24'd0, e[7:0]});
        if (bus.valid) last_valid_cyc = cyc;
      end
    end
    prev_pulse = rst_n & (bus.valid | bus.frame_err);
  end
  initial begin
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data", {24'd0, bus.data}, 0);
    check("rst_valid", {31'd0, bus.valid}, 0);
    check("rst_err", {31'd0, bus.frame_err}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    rst_n = 1'b1;
    hold(1'b1, 20);
    send_good(8'hA5);
    check("latency_lo", {31'd0, (last_valid_cyc - fall_cyc) >= 2225}, 1);
    check("latency_hi", {31'd0, (last_valid_cyc - fall_cyc) <= 2227}, 1);
    hold(1'b1, cc);
    hold(1'b0, 50);
    hold(1'b1, 10);
    check("glitch_busy", {31'd0, bus.busy}, 1);
    hold(1'b1, 65);
    check("glitch_idle", {31'd0, bus.busy}, 0);
    hold(1'b1, cc);
    send_good(8'h3C);
    send_bad(8'h55);
    check("err_keeps_data", {24'd0, bus.data}, {24'd0, last_good});
    q.push_back({1'b1, last_good});
    hold(1'b0, 20 * cc);
    hold(1'b1, 2 * cc);
    send_good(8'h81);
    send_good(8'h00);
    send_good(8'hFF);
    send_good(8'h12);
    hold(1'b1, cc);
    check("drained", q.size(), 0);
    hold(1'b0, cc);
    for (int i = 0; i < 4; i++) hold(1'(8'hF0 >> i), cc);
    hold(1'b1, cc / 2);
    rst_n = 1'b0;
    last_good = 8'h00;
    @(negedge clk);
    check("mid_rst_data", {24'd0, bus.data}, 0);
    check("mid_rst_valid", {31'd0, bus.valid}, 0);
    check("mid_rst_err", {31'd0, bus.frame_err}, 0);
    check("mid_rst_busy", {31'd0, bus.busy}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, cc);
    send_good(8'h0F);
    for (int n = 0; n < 15; n++) begin
      case ($urandom_range(0, 9))
        0: begin
          hold(1'b0, $urandom_range(1, 100));
          hold(1'b1, 200);
        end
        1: send_bad(8'($urandom));
        default: send_good(8'($urandom));
      endcase
      hold(1'b1, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 300) : 0);
    end
    hold(1'b1, 3 * cc);
    check("pending", q.size(), 0);
    check("final_data", {24'd0, bus.data}, {24'd0, last_good});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
